// File: rtl/hazard_pkg.sv
// Shared types for the EX forwarding / ID hazard control slice.
package hazard_pkg;

    // Per-lane EX operand mux select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Load-use stall sequencer
    typedef enum logic {
        HZ_IDLE,
        HZ_WAIT
    } hz_state_e;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15
    localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/fwd_sel_lane.sv
// One source-operand lane: picks MEM, WB or regfile data for an EX operand.
module fwd_sel_lane
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] rd_mem_i,
    input  logic            regwrite_mem_i,
    input  logic [RA_W-1:0] rd_wb_i,
    input  logic            regwrite_wb_i,
    output fwd_sel_e        sel_o
);

    logic match_mem;
    logic match_wb;

    // MEM result is newer than WB, so it wins when both match; x0 never forwards
    always_comb begin
        match_mem = regwrite_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i);
        match_wb  = regwrite_wb_i  && (rd_wb_i  != '0) && (rd_wb_i  == rs_i);
        sel_o     = FWD_RF;
        if (match_mem) begin
            sel_o = FWD_MEM;
        end else if (match_wb) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding plus ID load-use stall, branch flush and stall counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC*RA_W-1:0] rs_id,
    input  logic [NUM_SRC*RA_W-1:0] rs_ex,
    input  logic [RA_W-1:0]         rd_ex,
    input  logic                    memread_ex,
    input  logic [RA_W-1:0]         rd_mem,
    input  logic                    regwrite_mem,
    input  logic [RA_W-1:0]         rd_wb,
    input  logic                    regwrite_wb,
    input  logic                    branch_taken_ex,
    output logic [NUM_SRC*2-1:0]    forward_sel,
    output logic                    stall_pc,
    output logic                    stall_ifid,
    output logic                    bubble_idex,
    output logic                    flush_ifid,
    output logic                    flush_idex,
    output logic [CNT_W-1:0]        stall_count
);

    hz_state_e          state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_count_q;
    logic               load_use;
    logic               stall_act;
    logic               flush_act;
    fwd_sel_e           lane_sel [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        fwd_sel_lane #(.RA_W(RA_W)) u_lane (
            .rs_i           (rs_ex[g*RA_W +: RA_W]),
            .rd_mem_i       (rd_mem),
            .regwrite_mem_i (regwrite_mem),
            .rd_wb_i        (rd_wb),
            .regwrite_wb_i  (regwrite_wb),
            .sel_o          (lane_sel[g])
        );
        // Outputs are forced low while reset is held
        assign forward_sel[g*2 +: 2] = reset ? 2'b00 : lane_sel[g];
    end

    // Load-use: any ID source reads the (non-x0) destination of a load in EX
    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (memread_ex && (rd_ex != '0) && (rd_ex == rs_id[i*RA_W +: RA_W])) begin
                load_use = 1'b1;
            end
        end
    end

    // Stall is raised in the hazard cycle itself, then held through WAIT; flush masks it
    always_comb begin
        flush_act   = !reset && branch_taken_ex;
        stall_act   = !reset && !branch_taken_ex && ((state_q == HZ_WAIT) || load_use);
        stall_pc    = stall_act;
        stall_ifid  = stall_act;
        bubble_idex = stall_act;
        flush_ifid  = flush_act;
        flush_idex  = flush_act;
        stall_count = stall_count_q;
    end

    // Next state: IDLE covers the first stall cycle, WAIT covers the remaining MEM_LAT-1
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (branch_taken_ex) begin
            state_d = HZ_IDLE;
            wcnt_d  = '0;
        end else if (state_q == HZ_IDLE) begin
            if (load_use && (MEM_LAT > 1)) begin
                state_d = HZ_WAIT;
                wcnt_d  = WCNT_W'(MEM_LAT - 1);
            end
        end else begin
            if (wcnt_q <= WCNT_W'(1)) begin
                state_d = HZ_IDLE;
                wcnt_d  = '0;
            end else begin
                wcnt_d  = wcnt_q - WCNT_W'(1);
            end
        end
    end

    // State, wait counter and saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HZ_IDLE;
            wcnt_q        <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (stall_act && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

endmodule
